// File: rtl/adc_scan_seq.sv
// rtl/adc_scan_seq.sv - LTC2308 round-robin channel scan sequencer with sample register bank
module adc_scan_seq #(
  parameter int NUM_CH    = 8,
  parameter int CLK_DIV   = 2,
  parameter int TCONV_CYC = 80,
  parameter int RES_BITS  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        stop,
  input  logic        uni,
  output logic        busy,
  output logic        smp_valid,
  output logic [11:0] smp_data,
  output logic [2:0]  smp_ch,
  input  logic [2:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        ADC_CONVST,
  output logic        ADC_SCLK,
  output logic        ADC_DIN,
  input  logic        ADC_DOUT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_STORE = 3'd4
  } state_t;

  localparam logic [11:0] LP_TCONV_LAST = 12'(TCONV_CYC - 1);
  localparam logic [11:0] LP_DIV_LAST   = 12'(CLK_DIV - 1);
  localparam logic [3:0]  LP_BIT_LAST   = 4'(RES_BITS - 1);
  localparam logic [2:0]  LP_CH_LAST    = 3'(NUM_CH - 1);
  localparam logic [3:0]  LP_NUM_CH     = 4'(NUM_CH);

  state_t      r_state;
  state_t      w_next;

  // frame timing and serial shift engine
  logic [11:0] r_cnt;
  logic        r_phase;
  logic [3:0]  r_bit;
  logic [11:0] r_shift;
  logic [5:0]  r_cfg;

  // scan bookkeeping: r_ch_ptr is configured in the current frame,
  // r_prev_ch owns the result being shifted in during the current frame
  logic [2:0]  r_ch_ptr;
  logic [2:0]  r_prev_ch;
  logic        r_priming;
  logic        r_cont;
  logic        r_stop;

  // sample output and register bank
  logic        r_smp_valid;
  logic [11:0] r_smp_data;
  logic [2:0]  r_smp_ch;
  logic [11:0] r_bank [0:7];
  logic [11:0] r_rd_data;

  logic        w_div_end;
  logic        w_shift_done;
  logic        w_pass_end;
  logic        w_new_sample;
  logic [5:0]  w_cfg;

  assign w_div_end    = (r_cnt == LP_DIV_LAST);
  assign w_shift_done = r_phase && w_div_end && (r_bit == LP_BIT_LAST);
  // stop and end-of-pass only take effect once a real sample has been produced,
  // so a priming frame always runs into a sample frame
  assign w_pass_end   = !r_priming &&
                        (r_stop || stop || ((r_prev_ch == LP_CH_LAST) && !r_cont));
  assign w_new_sample = (r_state == S_SHIFT) && w_shift_done && !r_priming;
  // S/D, O/S, S1, S0, UNI, SLP in transmit order
  assign w_cfg        = {1'b1, r_ch_ptr[0], r_ch_ptr[2], r_ch_ptr[1], uni, 1'b0};

  assign smp_valid = r_smp_valid;
  assign smp_data  = r_smp_data;
  assign smp_ch    = r_smp_ch;
  assign rd_data   = r_rd_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)                  w_next = S_CONV;
      S_CONV:  if (r_cnt == 12'd1)         w_next = S_WAIT;
      S_WAIT:  if (r_cnt == LP_TCONV_LAST) w_next = S_SHIFT;
      S_SHIFT: if (w_shift_done)           w_next = S_STORE;
      S_STORE: w_next = w_pass_end ? S_IDLE : S_CONV;
      default: w_next = S_IDLE;
    endcase
  end

  // ADC pin and status decode from state and shift counters
  always_comb begin
    busy       = (r_state != S_IDLE);
    ADC_CONVST = (r_state == S_CONV);
    ADC_SCLK   = (r_state == S_SHIFT) && r_phase;
    ADC_DIN    = 1'b0;
    if ((r_state == S_SHIFT) && (r_bit < 4'd6)) begin
      ADC_DIN = r_cfg[3'd5 - r_bit[2:0]];
    end
  end

  // Frame timer, SCLK phase/bit counters and DOUT capture on SCLK rise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_shift <= '0;
      r_cfg   <= '0;
    end else begin
      if ((r_state == S_IDLE) || (r_state != w_next)) begin
        r_cnt <= '0;
      end else if ((r_state == S_SHIFT) && w_div_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 12'd1;
      end

      if (r_state == S_SHIFT) begin
        if (w_div_end) begin
          r_phase <= ~r_phase;
          if (!r_phase) begin
            r_shift <= {r_shift[10:0], ADC_DOUT};
          end else begin
            r_bit <= r_bit + 4'd1;
          end
        end
      end else begin
        r_phase <= 1'b0;
        r_bit   <= '0;
      end

      // clearing the shifter here keeps short results zero-extended
      if (r_state == S_CONV) begin
        r_shift <= '0;
        r_cfg   <= w_cfg;
      end
    end
  end

  // Channel pointer, priming flag, mode and stop latches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch_ptr  <= '0;
      r_prev_ch <= '0;
      r_priming <= 1'b0;
      r_cont    <= 1'b0;
      r_stop    <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_stop <= start & stop;
        if (start) begin
          r_ch_ptr  <= '0;
          r_prev_ch <= '0;
          r_priming <= 1'b1;
          r_cont    <= continuous;
        end
      end else if ((r_state == S_STORE) && (w_next == S_IDLE)) begin
        r_stop <= 1'b0;
      end else if (stop) begin
        r_stop <= 1'b1;
      end

      if ((r_state == S_STORE) && (w_next == S_CONV)) begin
        r_prev_ch <= r_ch_ptr;
        r_ch_ptr  <= (r_ch_ptr == LP_CH_LAST) ? 3'd0 : r_ch_ptr + 3'd1;
        r_priming <= 1'b0;
      end
    end
  end

  // Sample publish (valid during STORE) and bank write at the end of STORE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_smp_valid <= 1'b0;
      r_smp_data  <= '0;
      r_smp_ch    <= '0;
      for (int i = 0; i < 8; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      r_smp_valid <= w_new_sample;
      if (w_new_sample) begin
        r_smp_data <= r_shift;
        r_smp_ch   <= r_prev_ch;
      end
      if (r_smp_valid) begin
        r_bank[r_smp_ch] <= r_smp_data;
      end
    end
  end

  // Registered bank readback; unused channel addresses read as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= ({1'b0, rd_addr} < LP_NUM_CH) ? r_bank[rd_addr] : 12'd0;
    end
  end

endmodule
